// File: rtl/jtframe_sdram64_sched.sv
// SDRAM command-bus scheduler for four bank engines, with auto-refresh insertion.
// Define JTFRAME_SDRAM64_RR_EN for round-robin grants; otherwise bank0 has fixed highest priority.
module jtframe_sdram64_sched #(
   parameter int REFCNT  = 780,
   parameter int TRP     = 2,
   parameter int TRFC    = 7,
   parameter int MAXDEBT = 7
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  br,
   input  logic [15:0] bank_cmd,
   input  logic [47:0] bank_a,
   input  logic [3:0]  dbusy,
   input  logic [3:0]  dbusy64,
   input  logic [3:0]  dqm_busy,
   input  logic [3:0]  post_act,
   input  logic [3:0]  idle,
   input  logic        ref_en,
   output logic [3:0]  bg,
   output logic [3:0]  set_prech,
   output logic        all_dbusy,
   output logic        all_dbusy64,
   output logic        all_dqm,
   output logic        all_act,
   output logic        ref_busy,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_a
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam int         TW      = $clog2(REFCNT + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_PRE, ST_TRPW, ST_REF, ST_TRFCW
   } ref_state_t;

   ref_state_t    st, st_nxt;
   logic [7:0]    wait_cnt, wait_nxt;
   logic [TW-1:0] ref_timer;
   logic [2:0]    ref_debt;
   logic          ref_wrap, debt_dec;
   logic          act_q;
   logic          gnt_any, gnt_issue;
   logic [1:0]    gnt_idx;
   logic [3:0]    gnt_cmd;
   logic [11:0]   gnt_a;
   logic [3:0]    pin_cmd_nxt;
   logic [1:0]    pin_ba_nxt;
   logic [11:0]   pin_a_nxt;
`ifdef JTFRAME_SDRAM64_RR_EN
   logic [1:0]    last_bank, rr_cand;
`endif

   assign all_dbusy   = |dbusy;
   assign all_dbusy64 = |dbusy64;
   assign all_dqm     = |dqm_busy;
   assign all_act     = (|post_act) | act_q;
   assign ref_busy    = (st == ST_PRE) || (st == ST_TRPW) || (st == ST_REF) || (st == ST_TRFCW);

   // Grant selection; the refresh FSM masks all grants from REQ onwards
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = 2'd0;
`ifdef JTFRAME_SDRAM64_RR_EN
      rr_cand = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         rr_cand = last_bank + 2'(k);
         if (!gnt_any && br[rr_cand]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_cand;
         end
      end
`else
      for (int k = 3; k >= 0; k--) begin
         if (br[k]) begin
            gnt_any = 1'b1;
            gnt_idx = 2'(k);
         end
      end
`endif
      if (ref_busy || st == ST_REQ) gnt_any = 1'b0;
   end

   assign bg = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

   always_comb begin
      case (gnt_idx)
         2'd0:    begin gnt_cmd = bank_cmd[3:0];   gnt_a = bank_a[11:0];  end
         2'd1:    begin gnt_cmd = bank_cmd[7:4];   gnt_a = bank_a[23:12]; end
         2'd2:    begin gnt_cmd = bank_cmd[11:8];  gnt_a = bank_a[35:24]; end
         default: begin gnt_cmd = bank_cmd[15:12]; gnt_a = bank_a[47:36]; end
      endcase
   end

   assign gnt_issue = gnt_any && (gnt_cmd != CMD_NOP);

   always_comb begin
      pin_cmd_nxt = CMD_NOP;
      pin_ba_nxt  = sdram_ba;
      pin_a_nxt   = sdram_a;
      if (st == ST_PRE) begin
         pin_cmd_nxt = CMD_PRE;
         pin_a_nxt   = 12'h400;
      end else if (st == ST_REF) begin
         pin_cmd_nxt = CMD_REF;
      end else if (gnt_issue) begin
         pin_cmd_nxt = gnt_cmd;
         pin_ba_nxt  = gnt_idx;
         pin_a_nxt   = gnt_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdram_cmd <= CMD_NOP;
         sdram_ba  <= 2'd0;
         sdram_a   <= 12'd0;
         set_prech <= 4'h0;
         act_q     <= 1'b0;
`ifdef JTFRAME_SDRAM64_RR_EN
         last_bank <= 2'd3;
`endif
      end else begin
         sdram_cmd <= pin_cmd_nxt;
         sdram_ba  <= pin_ba_nxt;
         sdram_a   <= pin_a_nxt;
         set_prech <= {4{st == ST_PRE}};
         act_q     <= (pin_cmd_nxt == CMD_ACT);
`ifdef JTFRAME_SDRAM64_RR_EN
         if (gnt_issue) last_bank <= gnt_idx;
`endif
      end
   end

   // A wrap coinciding with the REFRESH cycle leaves the debt unchanged
   assign ref_wrap = ref_en && (ref_timer == TW'(REFCNT - 1));
   assign debt_dec = (st == ST_REF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_timer <= '0;
         ref_debt  <= 3'd0;
      end else begin
         if (ref_en) ref_timer <= ref_wrap ? '0 : ref_timer + TW'(1);
         if (!ref_en) begin
            ref_debt <= 3'd0;
         end else if (ref_wrap && !debt_dec) begin
            if (ref_debt != 3'(MAXDEBT)) ref_debt <= ref_debt + 3'd1;
         end else if (!ref_wrap && debt_dec && ref_debt != 3'd0) begin
            ref_debt <= ref_debt - 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         wait_cnt <= 8'd0;
      end else begin
         st       <= st_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      wait_nxt = wait_cnt;
      case (st)
         ST_IDLE: if (ref_debt != 3'd0) st_nxt = ST_REQ;
         ST_REQ: begin
            if (ref_debt == 3'd0) st_nxt = ST_IDLE;
            else if (idle == 4'hF && !all_dbusy64) st_nxt = ST_PRE;
         end
         ST_PRE: begin
            st_nxt   = ST_TRPW;
            wait_nxt = 8'(TRP - 1);
         end
         ST_TRPW: begin
            if (wait_cnt == 8'd0) st_nxt = ST_REF;
            else wait_nxt = wait_cnt - 8'd1;
         end
         ST_REF: begin
            st_nxt   = ST_TRFCW;
            wait_nxt = 8'(TRFC - 1);
         end
         ST_TRFCW: begin
            if (wait_cnt == 8'd0) st_nxt = (ref_debt != 3'd0) ? ST_PRE : ST_IDLE;
            else wait_nxt = wait_cnt - 8'd1;
         end
         default: st_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_jtframe_sdram64_sched.sv
// Bench for jtframe_sdram64_sched: directed scenarios plus random traffic against a timeline model
// of grants, pin latching and refresh debt.
module tb_jtframe_sdram64_sched;

   localparam int REFCNT  = 20;
   localparam int TRP     = 2;
   localparam int TRFC    = 7;
   localparam int MAXDEBT = 7;
   localparam int SEQ_LEN = TRP + TRFC + 2;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] ACT  = 4'b0011;
   localparam logic [3:0] RD   = 4'b0101;
   localparam logic [3:0] WR   = 4'b0100;
   localparam logic [3:0] PRE  = 4'b0010;
   localparam logic [3:0] REFC = 4'b0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  br = '0;
   logic [15:0] bank_cmd = {4{NOP}};
   logic [47:0] bank_a = '0;
   logic [3:0]  dbusy = '0, dbusy64 = '0, dqm_busy = '0, post_act = '0;
   logic [3:0]  idle = 4'hF;
   logic        ref_en = 1'b0;
   logic [3:0]  bg, set_prech;
   logic        all_dbusy, all_dbusy64, all_dqm, all_act, ref_busy;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [11:0] sdram_a;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: refresh is a fixed timeline of SEQ_LEN cycles (pos 0 = PRECHARGE,
   // pos TRP+1 = REFRESH); pos -1 means a refresh is owed and waiting for the banks, -2 means none.
   int          m_timer, m_debt, m_pos, m_last;
   logic [3:0]  e_cmd, e_setp;
   logic [1:0]  e_ba;
   logic [11:0] e_a, e_amask;
   logic        e_act;
   logic [3:0]  cmd_tab [4] = '{NOP, ACT, RD, WR};
   logic [3:0]  exp_seq [5];

   jtframe_sdram64_sched #(.REFCNT(REFCNT), .TRP(TRP), .TRFC(TRFC), .MAXDEBT(MAXDEBT)) dut (
      .clk(clk), .rst_n(rst_n), .br(br), .bank_cmd(bank_cmd), .bank_a(bank_a),
      .dbusy(dbusy), .dbusy64(dbusy64), .dqm_busy(dqm_busy), .post_act(post_act),
      .idle(idle), .ref_en(ref_en), .bg(bg), .set_prech(set_prech),
      .all_dbusy(all_dbusy), .all_dbusy64(all_dbusy64), .all_dqm(all_dqm),
      .all_act(all_act), .ref_busy(ref_busy), .sdram_cmd(sdram_cmd),
      .sdram_ba(sdram_ba), .sdram_a(sdram_a)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_grant();
      if (m_pos != -2) return -1;
`ifdef JTFRAME_SDRAM64_RR_EN
      for (int k = 1; k <= 4; k++) if (br[(m_last + k) % 4]) return (m_last + k) % 4;
`else
      for (int b = 0; b < 4; b++) if (br[b]) return b;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_timer = 0; m_debt = 0; m_pos = -2; m_last = 3;
      e_cmd = NOP; e_ba = 2'd0; e_a = 12'd0; e_amask = 12'hFFF; e_setp = 4'h0; e_act = 1'b0;
   endtask

   task automatic model_step();
      int  g, od, nd;
      logic wrap, dec;
      g    = m_grant();
      od   = m_debt;
      dec  = (m_pos == TRP + 1);
      e_setp = 4'h0;
      if (m_pos == 0) begin
         e_cmd = PRE; e_a = 12'h400; e_amask = 12'h400; e_setp = 4'hF;
      end else if (m_pos == TRP + 1) begin
         e_cmd = REFC;
      end else if (g >= 0 && bank_cmd[g*4 +: 4] != NOP) begin
         e_cmd = bank_cmd[g*4 +: 4]; e_ba = 2'(g); e_a = bank_a[g*12 +: 12];
         e_amask = 12'hFFF; m_last = g;
      end else begin
         e_cmd = NOP;
      end
      e_act = (e_cmd == ACT);
      wrap  = ref_en && (m_timer == REFCNT - 1);
      if (ref_en) m_timer = (m_timer + 1) % REFCNT;
      if (!ref_en) nd = 0;
      else begin
         nd = od + (wrap ? 1 : 0) - (dec ? 1 : 0);
         if (nd > MAXDEBT) nd = MAXDEBT;
         if (nd < 0) nd = 0;
      end
      if (m_pos == -2) begin
         if (od != 0) m_pos = -1;
      end else if (m_pos == -1) begin
         if (od == 0) m_pos = -2;
         else if (idle == 4'hF && dbusy64 == 4'h0) m_pos = 0;
      end else if (m_pos == SEQ_LEN - 1) begin
         m_pos = (od != 0) ? 0 : -2;
      end else begin
         m_pos++;
      end
      m_debt = nd;
   endtask

   task automatic check_all();
      int g;
      g = m_grant();
      chk("bg", 32'(bg), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("ref_busy", 32'(ref_busy), 32'(m_pos >= 0));
      chk("sdram_cmd", 32'(sdram_cmd), 32'(e_cmd));
      chk("sdram_ba", 32'(sdram_ba), 32'(e_ba));
      chk("sdram_a", 32'(sdram_a & e_amask), 32'(e_a & e_amask));
      chk("set_prech", 32'(set_prech), 32'(e_setp));
      chk("all_act", 32'(all_act), 32'((|post_act) | e_act));
      chk("all_dbusy", 32'(all_dbusy), 32'(|dbusy));
      chk("all_dbusy64", 32'(all_dbusy64), 32'(|dbusy64));
      chk("all_dqm", 32'(all_dqm), 32'(|dqm_busy));
   endtask

   // One cycle: check at the falling edge, advance the model at the rising edge, settle 1 time unit
   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; br = '0; bank_cmd = {4{NOP}}; bank_a = '0;
      dbusy = '0; dbusy64 = '0; dqm_busy = '0; post_act = '0; idle = 4'hF; ref_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Returns the number of ticks until sdram_cmd shows cmd (bound+1 on timeout)
   task automatic wait_cmd(input logic [3:0] cmd, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sdram_cmd != cmd && n <= bound);
   endtask

   initial begin
      int n, z, cnt;
`ifdef JTFRAME_SDRAM64_RR_EN
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      // Reset state
      do_reset();
      chk("rst_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("rst_ba", 32'(sdram_ba), 32'd0);
      chk("rst_a", 32'(sdram_a), 32'd0);
      chk("rst_bg", 32'(bg), 32'd0);
      chk("rst_set_prech", 32'(set_prech), 32'd0);
      chk("rst_ref_busy", 32'(ref_busy), 32'd0);
      chk("rst_all_act", 32'(all_act), 32'd0);

      // Single ACTIVE from bank0
      br = 4'b0001; bank_cmd[3:0] = ACT; bank_a[11:0] = 12'h123;
      #1 chk("t1_bg", 32'(bg), 32'b0001);
      tick();
      chk("t1_cmd", 32'(sdram_cmd), 32'(ACT));
      chk("t1_ba", 32'(sdram_ba), 32'd0);
      chk("t1_a", 32'(sdram_a), 32'h123);
      chk("t1_all_act", 32'(all_act), 32'd1);
      br = '0; bank_cmd = {4{NOP}};
      tick();
      tick();

      // All banks request and issue READ
      do_reset();
      br = 4'hF; bank_cmd = {RD, RD, RD, RD};
      bank_a = {12'hD03, 12'hC02, 12'hB01, 12'hA00};
      for (int i = 0; i < 5; i++) begin
         #1 chk("t2_grant", 32'(bg), 32'(exp_seq[i]));
         tick();
      end

      // Periodic refresh with all banks idle
      do_reset();
      ref_en = 1'b1;
      wait_cmd(PRE, 40, n);
      chk("t3_pre_time", 32'(n), 32'(REFCNT + 3));
      chk("t3_a10", 32'(sdram_a[10]), 32'd1);
      chk("t3_set_prech", 32'(set_prech), 32'hF);
      br = 4'hF; bank_cmd = {RD, RD, RD, RD};
      wait_cmd(REFC, 20, n);
      chk("t3_trp", 32'(n), 32'(TRP + 1));
      z = 0;
      while (bg == 4'h0 && z < 30) begin
         z++;
         tick();
      end
      chk("t3_trfc_block", 32'(z), 32'(TRFC));

      // Refresh stalls while a bank is busy
      idle = 4'b1011; dbusy64 = 4'b0100;
      n = 0;
      while (m_pos != -1 && n < 60) begin
         tick();
         n++;
      end
      chk("t4_reached_req", 32'(m_pos == -1), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t4_stall_bg", 32'(bg), 32'd0);
         chk("t4_stall_cmd", 32'(sdram_cmd), 32'(NOP));
      end
      idle = 4'hF; dbusy64 = 4'h0; br = '0;
      wait_cmd(PRE, 10, n);
      chk("t4_release", 32'(n), 32'd2);

      // Debt accumulates to 3, then three chained sequences
      do_reset();
      ref_en = 1'b1; idle = 4'h0;
      repeat (3 * REFCNT + 2) tick();
      idle = 4'hF;
      cnt = 0;
      for (int i = 0; i < 34; i++) begin
         tick();
         if (sdram_cmd == REFC) cnt++;
      end
      chk("t5_refresh_count", 32'(cnt), 32'd3);

      // Reset during TRFC wait clears pins, busy and debt
      do_reset();
      ref_en = 1'b1; idle = 4'h0;
      repeat (2 * REFCNT + 2) tick();
      idle = 4'hF;
      wait_cmd(REFC, 20, n);
      chk("t6_refresh_seen", 32'(sdram_cmd), 32'(REFC));
      tick();
      tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("t6_rst_busy", 32'(ref_busy), 32'd0);
      chk("t6_rst_set_prech", 32'(set_prech), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < REFCNT; i++) begin
         tick();
         if (sdram_cmd == PRE) cnt++;
      end
      chk("t6_debt_cleared", 32'(cnt), 32'd0);

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         br = 4'($urandom_range(0, 15));
         for (int b = 0; b < 4; b++) bank_cmd[b*4 +: 4] = cmd_tab[$urandom_range(0, 3)];
         bank_a   = {16'($urandom), 32'($urandom)};
         dbusy    = 4'($urandom);
         dqm_busy = 4'($urandom);
         post_act = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         dbusy64  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
         idle     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
         ref_en   = ($urandom_range(0, 29) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
